// File: rtl/mac_chain_pipe.sv
// Pipelined multiply-add chain: stage k registers (y(k-1)*b + c) mod 2^W, with a
// global-stall valid/ready handshake and an optional running accumulator at the output.
module mac_chain_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [DATA_WIDTH-1:0] in_c,
  input  logic                  in_mode,
  input  logic                  acc_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0] acc_value
);

  localparam int W    = DATA_WIDTH;
  localparam int LAST = DEPTH - 1;

  logic stall;
  logic adv;
  logic accept;

  // Stage registers; index k holds pipeline stage k+1.
  logic         valid_q [DEPTH];
  logic         valid_d [DEPTH];
  logic [W-1:0] y_q     [DEPTH];
  logic [W-1:0] y_d     [DEPTH];
  logic [W-1:0] b_q     [DEPTH];
  logic [W-1:0] b_d     [DEPTH];
  logic [W-1:0] c_q     [DEPTH];
  logic [W-1:0] c_d     [DEPTH];
  logic         mode_q  [DEPTH];
  logic         mode_d  [DEPTH];

  // Operands feeding each stage and that stage's chain result.
  logic         src_valid [DEPTH];
  logic [W-1:0] src_y     [DEPTH];
  logic [W-1:0] src_b     [DEPTH];
  logic [W-1:0] src_c     [DEPTH];
  logic         src_mode  [DEPTH];
  logic [2*W-1:0] prod    [DEPTH];
  logic [W-1:0] chain_y   [DEPTH];

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;
  logic [W-1:0] acc_base;
  logic [W-1:0] acc_sum;

  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gen_stage
      if (gi == 0) begin : gen_first
        assign src_valid[gi] = accept;
        assign src_y[gi]     = in_a;
        assign src_b[gi]     = in_b;
        assign src_c[gi]     = in_c;
        assign src_mode[gi]  = in_mode;
      end else begin : gen_next
        assign src_valid[gi] = valid_q[gi-1];
        assign src_y[gi]     = y_q[gi-1];
        assign src_b[gi]     = b_q[gi-1];
        assign src_c[gi]     = c_q[gi-1];
        assign src_mode[gi]  = mode_q[gi-1];
      end
      // Full-width product first, then keep the low W bits of product + c.
      assign prod[gi]    = {{W{1'b0}}, src_y[gi]} * {{W{1'b0}}, src_b[gi]};
      assign chain_y[gi] = W'(prod[gi] + {{W{1'b0}}, src_c[gi]});
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k];
      y_d[k]     = y_q[k];
      b_d[k]     = b_q[k];
      c_d[k]     = c_q[k];
      mode_d[k]  = mode_q[k];
    end
    // Clear is applied before any add so a coincident load yields acc = y.
    acc_base = acc_clr ? '0 : acc_q;
    acc_sum  = acc_base + chain_y[LAST];
    acc_d    = acc_base;
    if (adv) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_d[k] = src_valid[k];
        y_d[k]     = chain_y[k];
        b_d[k]     = src_b[k];
        c_d[k]     = src_c[k];
        mode_d[k]  = src_mode[k];
      end
      if (src_valid[LAST] && src_mode[LAST]) begin
        acc_d      = acc_sum;
        y_d[LAST]  = acc_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        y_q[k]     <= '0;
        b_q[k]     <= '0;
        c_q[k]     <= '0;
        mode_q[k]  <= 1'b0;
      end
      acc_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= valid_d[k];
        y_q[k]     <= y_d[k];
        b_q[k]     <= b_d[k];
        c_q[k]     <= c_d[k];
        mode_q[k]  <= mode_d[k];
      end
      acc_q <= acc_d;
    end
  end

  assign out_valid = valid_q[LAST];
  assign out_data  = y_q[LAST];
  assign acc_value = acc_q;

endmodule
